// File: rtl/int_arbiter_if.sv
// Bus, request and CP0 handshake signals of the interrupt arbiter.
// The master side drives requests and register accesses; the arbiter is the slave.
interface int_arbiter_if;
  logic [5:0]  IrqIn;
  logic [1:0]  Addr;
  logic        WE;
  logic [31:0] DIn;
  logic [31:0] DOut;
  logic        Taken;
  logic [5:0]  HWInt;

  modport master (
    output IrqIn, Addr, WE, DIn, Taken,
    input  DOut, HWInt
  );

  modport slave (
    input  IrqIn, Addr, WE, DIn, Taken,
    output DOut, HWInt
  );
endinterface

// File: rtl/int_arbiter.sv
// Six-source fixed-priority interrupt arbiter with MASK/EDGE/PEND/ISR registers and a non-nesting IDLE/ASSERT/SERVICE handshake.
// Optional macro INT_ARBITER_SYNC_EN adds two synchroniser flops ahead of irq_s.
module int_arbiter (
  input  logic         Clk,
  input  logic         Reset,
  int_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ASSERT  = 2'b01,
    SERVICE = 2'b10
  } state_t;

  state_t     state_reg, state_next;
  logic [5:0] sync_out;
  logic [5:0] irq_s, irq_d;
  logic [5:0] mask_reg, edge_reg, pend_reg, pend_next;
  logic [5:0] gnt_reg, gnt_next;
  logic [5:0] eligible, top_pick;
  logic       wr_mask, wr_edge, wr_pend, wr_eoi, taken_ok;
  logic       unused_din;

`ifdef INT_ARBITER_SYNC_EN
  logic [5:0] sync1_reg, sync2_reg;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= bus.IrqIn;
      sync2_reg <= sync1_reg;
    end
  end

  assign sync_out = sync2_reg;
`else
  assign sync_out = bus.IrqIn;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      irq_s <= '0;
      irq_d <= '0;
    end else begin
      irq_s <= sync_out;
      irq_d <= irq_s;
    end
  end

  assign wr_mask    = bus.WE && (bus.Addr == 2'd0);
  assign wr_edge    = bus.WE && (bus.Addr == 2'd1);
  assign wr_pend    = bus.WE && (bus.Addr == 2'd2);
  assign wr_eoi     = bus.WE && (bus.Addr == 2'd3);
  assign taken_ok   = bus.Taken && (state_reg == ASSERT);
  assign eligible   = pend_reg & mask_reg;
  assign unused_din = ^bus.DIn[31:6];

  // Edge sources latch a rising edge; a coincident clear loses to the set.
  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_pend
      logic set_edge, clr_edge;
      assign set_edge = irq_s[gi] & ~irq_d[gi];
      assign clr_edge = (wr_pend & bus.DIn[gi]) | (taken_ok & gnt_reg[gi]);
      assign pend_next[gi] = edge_reg[gi] ? (set_edge | (pend_reg[gi] & ~clr_edge))
                                          : irq_s[gi];
    end
  endgenerate

  // Scan upward so the highest eligible source is the last one written.
  always_comb begin
    top_pick = '0;
    for (int i = 0; i < 6; i++) begin
      if (eligible[i]) begin
        top_pick    = '0;
        top_pick[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      mask_reg <= '0;
      edge_reg <= '0;
      pend_reg <= '0;
    end else begin
      if (wr_mask) mask_reg <= bus.DIn[5:0];
      if (wr_edge) edge_reg <= bus.DIn[5:0];
      pend_reg <= pend_next;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg <= IDLE;
      gnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      gnt_reg   <= gnt_next;
    end
  end

  // ASSERT holds its grant; a newer higher-priority request waits for IDLE.
  always_comb begin
    state_next = state_reg;
    gnt_next   = gnt_reg;
    case (state_reg)
      IDLE: begin
        if (|eligible) begin
          state_next = ASSERT;
          gnt_next   = top_pick;
        end
      end
      ASSERT: begin
        if (bus.Taken) begin
          state_next = SERVICE;
        end else if (~|(gnt_reg & eligible)) begin
          state_next = IDLE;
          gnt_next   = '0;
        end
      end
      SERVICE: begin
        if (wr_eoi) begin
          state_next = IDLE;
          gnt_next   = '0;
        end
      end
      default: begin
        state_next = IDLE;
        gnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    bus.DOut = '0;
    case (bus.Addr)
      2'd0:    bus.DOut = {26'b0, mask_reg};
      2'd1:    bus.DOut = {26'b0, edge_reg};
      2'd2:    bus.DOut = {26'b0, pend_reg};
      default: bus.DOut = {22'b0, state_reg, 2'b0, gnt_reg};
    endcase
  end

  assign bus.HWInt = (state_reg == ASSERT) ? gnt_reg : '0;

endmodule

// File: tb/tb_int_arbiter.sv
// Randomised and directed checks of int_arbiter against a cycle-level behavioural model.
`timescale 1ns/100ps
module tb_int_arbiter;

  localparam int S_IDLE    = 0;
  localparam int S_ASSERT  = 1;
  localparam int S_SERVICE = 2;

  logic Clk = 1'b0;
  logic Reset;
  int_arbiter_if bus();

  int_arbiter dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  always #10 Clk = ~Clk;

  int n_vectors     = 0;
  int n_miscompares = 0;

  // Behavioural model state
  logic [5:0] m_irq_s, m_irq_d, m_mask, m_edge, m_pend, m_gnt;
  logic [5:0] m_s1, m_s2;
  int         m_state;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vectors++;
    if (obs !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [5:0] highest_onehot(input logic [5:0] v);
    for (int i = 5; i >= 0; i--)
      if (v[i]) return 6'b000001 << i;
    return 6'b0;
  endfunction

  function automatic logic [31:0] model_read(input int a);
    case (a)
      0:       return {26'b0, m_mask};
      1:       return {26'b0, m_edge};
      2:       return {26'b0, m_pend};
      default: return 32'(m_state * 256) + 32'(m_gnt);
    endcase
  endfunction

  task automatic cycle(input logic rst, input logic [5:0] irq, input logic [1:0] addr,
                       input logic we, input logic [31:0] din, input logic tk);
    logic [5:0] n_irq_s, n_irq_d, n_mask, n_edge, n_pend, n_gnt, n_s1, n_s2, elig;
    int         n_state;
    logic       rise, clr;
    Reset     = rst;
    bus.IrqIn = irq;
    bus.Addr  = addr;
    bus.WE    = we;
    bus.DIn   = din;
    bus.Taken = tk;

    if (rst) begin
      {n_irq_s, n_irq_d, n_mask, n_edge, n_pend, n_gnt, n_s1, n_s2} = '0;
      n_state = S_IDLE;
    end else begin
      n_s1 = irq;
      n_s2 = m_s1;
`ifdef INT_ARBITER_SYNC_EN
      n_irq_s = m_s2;
`else
      n_irq_s = irq;
`endif
      n_irq_d = m_irq_s;
      n_mask  = (we && addr == 2'd0) ? din[5:0] : m_mask;
      n_edge  = (we && addr == 2'd1) ? din[5:0] : m_edge;
      for (int i = 0; i < 6; i++) begin
        if (m_edge[i]) begin
          rise = m_irq_s[i] && !m_irq_d[i];
          clr  = (we && addr == 2'd2 && din[i]) || (m_state == S_ASSERT && tk && m_gnt[i]);
          n_pend[i] = rise ? 1'b1 : (clr ? 1'b0 : m_pend[i]);
        end else begin
          n_pend[i] = m_irq_s[i];
        end
      end
      elig    = m_pend & m_mask;
      n_state = m_state;
      n_gnt   = m_gnt;
      if (m_state == S_IDLE && elig != 0) begin
        n_state = S_ASSERT;
        n_gnt   = highest_onehot(elig);
      end else if (m_state == S_ASSERT && tk) begin
        n_state = S_SERVICE;
      end else if (m_state == S_ASSERT && (m_gnt & elig) == 0) begin
        n_state = S_IDLE;
        n_gnt   = 0;
      end else if (m_state == S_SERVICE && we && addr == 2'd3) begin
        n_state = S_IDLE;
        n_gnt   = 0;
      end
    end

    @(posedge Clk);
    #1;
    m_irq_s = n_irq_s; m_irq_d = n_irq_d; m_mask = n_mask; m_edge = n_edge;
    m_pend  = n_pend;  m_gnt   = n_gnt;   m_s1   = n_s1;   m_s2   = n_s2;
    m_state = n_state;
    bus.WE    = 1'b0;
    bus.Taken = 1'b0;

    check_val("hwint", {26'b0, bus.HWInt}, (m_state == S_ASSERT) ? {26'b0, m_gnt} : 32'd0);
    for (int a = 0; a < 4; a++) begin
      bus.Addr = a[1:0];
      #1;
      check_val($sformatf("dout[%0d]", a), bus.DOut, model_read(a));
    end
  endtask

  task automatic idle(input int n, input logic [5:0] irq);
    for (int i = 0; i < n; i++) cycle(1'b0, irq, 2'd0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic expect_read(input string tag, input logic [1:0] a, input logic [31:0] exp);
    bus.Addr = a;
    #1;
    check_val(tag, bus.DOut, exp);
  endtask

`ifdef INT_ARBITER_SYNC_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 3;
`endif

  logic [5:0]  r_irq;
  logic [1:0]  r_addr;
  logic [31:0] r_din;
  logic        r_we, r_tk, r_rst;

  initial begin
    {m_irq_s, m_irq_d, m_mask, m_edge, m_pend, m_gnt, m_s1, m_s2} = '0;
    m_state = S_IDLE;
    Reset = 1'b1; bus.IrqIn = '0; bus.Addr = '0; bus.WE = 1'b0; bus.DIn = '0; bus.Taken = 1'b0;

    cycle(1'b1, 6'h00, 2'd0, 1'b0, 32'd0, 1'b0);
    cycle(1'b1, 6'h00, 2'd0, 1'b0, 32'd0, 1'b0);
    check_val("reset_hwint", {26'b0, bus.HWInt}, 32'd0);
    for (int a = 0; a < 4; a++) expect_read($sformatf("reset_dout%0d", a), a[1:0], 32'd0);

    // Level path
    cycle(1'b0, 6'h00, 2'd0, 1'b1, 32'h3F, 1'b0);
    idle(LAT, 6'h04);
    check_val("lvl_hwint", {26'b0, bus.HWInt}, 32'h04);
    cycle(1'b0, 6'h04, 2'd0, 1'b0, 32'd0, 1'b1);
    check_val("lvl_taken_hwint", {26'b0, bus.HWInt}, 32'h00);
    expect_read("lvl_isr", 2'd3, 32'h204);
    idle(LAT, 6'h00);
    cycle(1'b0, 6'h00, 2'd3, 1'b1, 32'hDEAD_BEEF, 1'b0);
    expect_read("lvl_eoi_isr", 2'd3, 32'h000);

    // Priority
    idle(LAT, 6'h21);
    check_val("prio_hwint", {26'b0, bus.HWInt}, 32'h20);
    cycle(1'b0, 6'h21, 2'd0, 1'b0, 32'd0, 1'b1);
    idle(LAT, 6'h01);
    cycle(1'b0, 6'h01, 2'd3, 1'b1, 32'd0, 1'b0);
    idle(1, 6'h01);
    check_val("prio_second_hwint", {26'b0, bus.HWInt}, 32'h01);
    cycle(1'b0, 6'h01, 2'd0, 1'b0, 32'd0, 1'b1);
    idle(LAT, 6'h00);
    cycle(1'b0, 6'h00, 2'd3, 1'b1, 32'd0, 1'b0);

    // Edge latch with a one-cycle pulse
    cycle(1'b0, 6'h00, 2'd1, 1'b1, 32'h02, 1'b0);
    cycle(1'b0, 6'h02, 2'd0, 1'b0, 32'd0, 1'b0);
    idle(LAT - 2, 6'h00);
    expect_read("edge_pend", 2'd2, 32'h02);
    idle(1, 6'h00);
    check_val("edge_hwint", {26'b0, bus.HWInt}, 32'h02);
    cycle(1'b0, 6'h00, 2'd0, 1'b0, 32'd0, 1'b1);
    expect_read("edge_pend_taken", 2'd2, 32'h00);
    cycle(1'b0, 6'h00, 2'd3, 1'b1, 32'd0, 1'b0);
    cycle(1'b0, 6'h00, 2'd1, 1'b1, 32'h00, 1'b0);

    // Withdraw by masking, then Taken racing the withdraw
    idle(LAT, 6'h08);
    check_val("wd_hwint", {26'b0, bus.HWInt}, 32'h08);
    cycle(1'b0, 6'h08, 2'd0, 1'b1, 32'h37, 1'b0);
    check_val("wd_hold_hwint", {26'b0, bus.HWInt}, 32'h08);
    idle(1, 6'h08);
    check_val("wd_hwint_zero", {26'b0, bus.HWInt}, 32'h00);
    expect_read("wd_isr", 2'd3, 32'h000);
    cycle(1'b0, 6'h08, 2'd0, 1'b1, 32'h3F, 1'b0);
    idle(1, 6'h08);
    check_val("wd_reassert", {26'b0, bus.HWInt}, 32'h08);
    cycle(1'b0, 6'h08, 2'd0, 1'b1, 32'h37, 1'b0);
    cycle(1'b0, 6'h08, 2'd0, 1'b0, 32'd0, 1'b1);
    expect_read("wd_taken_isr", 2'd3, 32'h208);
    idle(LAT, 6'h00);
    cycle(1'b0, 6'h00, 2'd0, 1'b1, 32'h3F, 1'b0);
    cycle(1'b0, 6'h00, 2'd3, 1'b1, 32'd0, 1'b0);

    // Set beats write-1-to-clear on bit 4; then reset from SERVICE
    cycle(1'b0, 6'h00, 2'd1, 1'b1, 32'h10, 1'b0);
    cycle(1'b0, 6'h10, 2'd0, 1'b0, 32'd0, 1'b0);
    idle(LAT - 3, 6'h10);
    cycle(1'b0, 6'h10, 2'd2, 1'b1, 32'h10, 1'b0);
    expect_read("set_wins_pend", 2'd2, 32'h10);
    idle(1, 6'h10);
    cycle(1'b0, 6'h10, 2'd0, 1'b0, 32'd0, 1'b1);
    expect_read("svc_isr", 2'd3, 32'h210);
    cycle(1'b1, 6'h10, 2'd0, 1'b1, 32'h3F, 1'b1);
    check_val("rst_svc_hwint", {26'b0, bus.HWInt}, 32'd0);
    for (int a = 0; a < 4; a++) expect_read($sformatf("rst_svc_dout%0d", a), a[1:0], 32'd0);

    // Random traffic
    r_irq = '0;
    for (int n = 0; n < 3000; n++) begin
      r_rst  = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 3) == 0) r_irq = 6'($urandom) & 6'($urandom);
      r_we   = ($urandom_range(0, 3) == 0);
      r_addr = 2'($urandom);
      r_din  = $urandom;
      if (r_we && r_addr == 2'd0 && $urandom_range(0, 1) == 1) r_din[5:0] = 6'h3F;
      r_tk   = (m_state == S_ASSERT) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
      cycle(r_rst, r_irq, r_addr, r_we, r_din, r_tk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
